// File: rtl/snn_pkg.sv
// Shared types for the SNN step controller: FSM state encoding and index-width helper.
// Optional refractory logic in the controller is enabled with the REFRAC_EN macro.
package snn_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_DONE
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_argmax.sv
// Combinational argmax over packed spike counters; the lowest index wins ties
// because a later entry replaces the best only when strictly greater.
module snn_argmax import snn_pkg::*; #(
  parameter  int NUM_NEURONS = 4,
  parameter  int CNT_W       = 8,
  localparam int IDX_W       = idxWidth(NUM_NEURONS)
) (
  input  logic [NUM_NEURONS*CNT_W-1:0] i_counts,
  output logic [IDX_W-1:0]             o_index,
  output logic [CNT_W-1:0]             o_count
);

  always_comb begin
    o_index = '0;
    o_count = i_counts[CNT_W-1:0];
    for (int i = 1; i < NUM_NEURONS; i++) begin
      if (i_counts[i*CNT_W +: CNT_W] > o_count) begin
        o_index = IDX_W'(i);
        o_count = i_counts[i*CNT_W +: CNT_W];
      end
    end
  end

endmodule

// File: rtl/snn_step_controller.sv
// Sequences one SNN sample: clear, then NUM_STEPS x (strobe, settle, sample), then argmax.
// Define REFRAC_EN to add per-neuron refractory hold/masking of length REFRAC steps.
module snn_step_controller import snn_pkg::*; #(
  parameter  int NUM_NEURONS   = 4,
  parameter  int NUM_STEPS     = 16,
  parameter  int SETTLE_CYCLES = 2,
  parameter  int CNT_W         = 8,
  parameter  int REFRAC        = 2,
  localparam int IDX_W         = idxWidth(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   step_strobe,
  output logic [NUM_NEURONS-1:0] neuron_rst,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       winner,
  output logic [CNT_W-1:0]       winner_count
);

  localparam int STEP_W   = idxWidth(NUM_STEPS);
  localparam int SETTLE_W = idxWidth(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                       r_state, w_nextState;
  logic [STEP_W-1:0]            r_stepIdx;
  logic [SETTLE_W-1:0]          r_settleCnt;
  logic [CNT_W-1:0]             r_counts [NUM_NEURONS];
  logic [IDX_W-1:0]             r_winner;
  logic [CNT_W-1:0]             r_winnerCount;
  logic [NUM_NEURONS*CNT_W-1:0] w_countsFlat;
  logic [NUM_NEURONS-1:0]       w_holdRst;
  logic [NUM_NEURONS-1:0]       w_countMask;
  logic [NUM_NEURONS-1:0]       w_nrst;
  logic                         w_strobe;
  logic                         w_lastStep;
  logic                         w_settleDone;
  logic [IDX_W-1:0]             w_argIdx;
  logic [CNT_W-1:0]             w_argCnt;

  assign w_lastStep   = (r_stepIdx == STEP_W'(NUM_STEPS - 1));
  assign w_settleDone = (r_settleCnt == SETTLE_W'(SETTLE_CYCLES - 1));

`ifdef REFRAC_EN
  localparam int REF_W = idxWidth(REFRAC + 1);
  logic [REF_W-1:0] r_refrac [NUM_NEURONS];

  always_comb begin
    w_holdRst = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_holdRst[i] = (r_refrac[i] != '0);
  end

  // A refractory neuron counts down instead of reloading, so it cannot count again until expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_refrac[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_refrac[i] <= '0;
    end else if (r_state == S_SAMPLE) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (r_refrac[i] != '0)   r_refrac[i] <= r_refrac[i] - 1'b1;
        else if (spike_in[i])    r_refrac[i] <= REF_W'(REFRAC);
      end
    end
  end
`else
  assign w_holdRst = '0;
`endif

  assign w_countMask = spike_in & ~w_holdRst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_counts[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_counts[i] <= '0;
    end else if (r_state == S_SAMPLE) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        if (w_countMask[i] && (r_counts[i] != CNT_MAX)) r_counts[i] <= r_counts[i] + 1'b1;
    end
  end

  always_comb begin
    w_countsFlat = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_countsFlat[i*CNT_W +: CNT_W] = r_counts[i];
  end

  snn_argmax #(
    .NUM_NEURONS(NUM_NEURONS),
    .CNT_W      (CNT_W)
  ) u_argmax (
    .i_counts(w_countsFlat),
    .o_index (w_argIdx),
    .o_count (w_argCnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_stepIdx     <= '0;
      r_settleCnt   <= '0;
      r_winner      <= '0;
      r_winnerCount <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_CLEAR: begin
          r_stepIdx   <= '0;
          r_settleCnt <= '0;
        end
        S_DRIVE:  r_settleCnt <= '0;
        S_SETTLE: if (!w_settleDone) r_settleCnt <= r_settleCnt + 1'b1;
        S_SAMPLE: if (!w_lastStep) r_stepIdx <= r_stepIdx + 1'b1;
        S_DECIDE: begin
          r_winner      <= w_argIdx;
          r_winnerCount <= w_argCnt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_strobe    = 1'b0;
    w_nrst      = '0;
    case (r_state)
      S_IDLE:   if (start) w_nextState = S_CLEAR;
      S_CLEAR: begin
        w_nrst      = '1;
        w_nextState = S_DRIVE;
      end
      S_DRIVE: begin
        w_strobe    = 1'b1;
        w_nextState = S_SETTLE;
      end
      S_SETTLE: if (w_settleDone) w_nextState = S_SAMPLE;
      S_SAMPLE: begin
        w_nrst      = spike_in;
        w_nextState = w_lastStep ? S_DECIDE : S_DRIVE;
      end
      S_DECIDE: w_nextState = S_DONE;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Neuron resets are forced while rst is held so the array starts from rest.
  assign neuron_rst   = rst ? '1 : (w_nrst | w_holdRst);
  assign step_strobe  = w_strobe;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign winner       = r_winner;
  assign winner_count = r_winnerCount;

endmodule
